// File: rtl/segasys1_hs_pkg.sv
// Shared types for the SYSTEM1 hiscore engine: FSM states, range-table entry
// and the main-RAM decode constant.
package segasys1_hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_SEEK,
        ST_S_RD,
        ST_S_WR,
        ST_R_RD,
        ST_R_WR,
        ST_FIN
    } hs_state_e;

    typedef struct packed {
        logic [15:0] start;
        logic [8:0]  len;
    } rng_entry_t;

    // Upper address nibble of the SYSTEM1 main work RAM (0xC000-0xCFFF)
    localparam logic [3:0] HS_MAIN_RAM_HI = 4'b1100;

    function automatic logic entry_en(input rng_entry_t e);
        return e.len != '0;
    endfunction

endpackage

// File: rtl/segasys1_hs_table.sv
// Range table for the hiscore engine: NRANGE config-written entries and a
// search for the lowest-indexed enabled entry at or above a start index.
module segasys1_hs_table
    import segasys1_hs_pkg::*;
#(
    parameter int NRANGE = 4,
    localparam int IW = $clog2(NRANGE)
) (
    input  logic          clk48M,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  rng_entry_t    wr_ent,
    input  logic [IW:0]   from,
    output logic          found,
    output logic [IW-1:0] found_idx,
    output rng_entry_t    found_ent
);

    rng_entry_t ents [NRANGE];

    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NRANGE; i++) ents[i] <= '0;
        end else if (we) begin
            ents[idx] <= wr_ent;
        end
    end

    // Scan high to low so the last hit is the lowest qualifying index
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        found_ent = '0;
        for (int i = NRANGE - 1; i >= 0; i--) begin
            if (entry_en(ents[i]) && (i >= int'(from))) begin
                found     = 1'b1;
                found_idx = IW'(i);
                found_ent = ents[i];
            end
        end
    end

endmodule

// File: rtl/segasys1_hiscore_engine.sv
// Hiscore port initiator: pauses the game, then copies the configured game-RAM
// ranges to NVRAM (save) or back from NVRAM (restore), byte by byte.
module segasys1_hiscore_engine
    import segasys1_hs_pkg::*;
#(
    parameter int NRANGE    = 4,
    parameter int NV_AW     = 10,
    parameter int RD_LAT    = 2,
    parameter int PAUSE_CYC = 16,
    localparam int IW = $clog2(NRANGE)
) (
    input  logic             clk48M,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [15:0]      cfg_start,
    input  logic [8:0]       cfg_len,
    input  logic             start_save,
    input  logic             start_rest,
    output logic             PAUSE_N,
    output logic [15:0]      HSAD,
    output logic [7:0]       HSDI,
    output logic             HSWE,
    input  logic [7:0]       HSDO,
    output logic [NV_AW-1:0] nv_ad,
    output logic [7:0]       nv_dout,
    output logic             nv_we,
    input  logic [7:0]       nv_din,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int PC_W = $clog2(PAUSE_CYC + 1);
    localparam int WC_W = $clog2(RD_LAT + 1);
    localparam logic [NV_AW-1:0] NV_MAX = '1;

    hs_state_e        state, state_nxt;
    logic             mode_save;
    logic [PC_W-1:0]  pause_cnt;
    logic [WC_W-1:0]  wait_cnt;
    logic [15:0]      hsad_q;
    logic [NV_AW-1:0] nv_ad_q;
    logic [8:0]       cnt;
    logic [IW:0]      nxt_idx;
    logic             nv_end;
    logic             ovf_q;

    logic             srch_found;
    logic [IW-1:0]    srch_idx;
    rng_entry_t       srch_ent;

    wire start_any = start_save | start_rest;
    wire last_nv   = (nv_ad_q == NV_MAX);
    wire last_byte = (cnt == 9'd1);

    segasys1_hs_table #(.NRANGE(NRANGE)) u_table (
        .clk48M    (clk48M),
        .reset     (reset),
        .we        (cfg_we && (state == ST_IDLE)),
        .idx       (cfg_idx),
        .wr_ent    ('{start: cfg_start, len: cfg_len}),
        .from      (nxt_idx),
        .found     (srch_found),
        .found_idx (srch_idx),
        .found_ent (srch_ent)
    );

    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start_any) state_nxt = ST_PAUSE;
            ST_PAUSE: if (pause_cnt == PC_W'(PAUSE_CYC - 1)) state_nxt = ST_SEEK;
            ST_SEEK: begin
                // A further enabled range after the last NVRAM byte is an overflow
                if (!srch_found || nv_end) state_nxt = ST_FIN;
                else                       state_nxt = mode_save ? ST_S_RD : ST_R_RD;
            end
            ST_S_RD:  if (wait_cnt == WC_W'(RD_LAT - 1)) state_nxt = ST_S_WR;
            ST_S_WR: begin
                if (last_nv && !last_byte) state_nxt = ST_FIN;
                else if (last_byte)        state_nxt = ST_SEEK;
                else                       state_nxt = ST_S_RD;
            end
            ST_R_RD:  state_nxt = ST_R_WR;
            ST_R_WR: begin
                if (last_nv && !last_byte) state_nxt = ST_FIN;
                else if (last_byte)        state_nxt = ST_SEEK;
                else                       state_nxt = ST_R_RD;
            end
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        PAUSE_N = (state == ST_IDLE) || (state == ST_FIN);
        busy    = !PAUSE_N;
        done    = (state == ST_FIN);
        nv_we   = (state == ST_S_WR);
        nv_dout = nv_we ? HSDO : 8'h00;
        HSWE    = (state == ST_R_WR);
        HSDI    = HSWE ? nv_din : 8'h00;
        HSAD    = hsad_q;
        nv_ad   = nv_ad_q;
        ovf     = ovf_q;
    end

    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            mode_save <= 1'b0;
            pause_cnt <= '0;
            wait_cnt  <= '0;
            hsad_q    <= '0;
            nv_ad_q   <= '0;
            cnt       <= '0;
            nxt_idx   <= '0;
            nv_end    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_any) begin
                        mode_save <= start_save;
                        pause_cnt <= '0;
                        nv_ad_q   <= '0;
                        nxt_idx   <= '0;
                        nv_end    <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                ST_PAUSE: pause_cnt <= pause_cnt + 1'b1;
                ST_SEEK: begin
                    if (srch_found) begin
                        if (nv_end) begin
                            ovf_q <= 1'b1;
                        end else begin
                            hsad_q   <= srch_ent.start;
                            cnt      <= srch_ent.len;
                            nxt_idx  <= {1'b0, srch_idx} + 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_S_RD: wait_cnt <= wait_cnt + 1'b1;
                ST_S_WR, ST_R_WR: begin
                    hsad_q   <= hsad_q + 16'd1;
                    nv_ad_q  <= nv_ad_q + 1'b1;
                    cnt      <= cnt - 9'd1;
                    wait_cnt <= '0;
                    if (last_nv) begin
                        nv_end <= 1'b1;
                        if (!last_byte) ovf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segasys1_hiscore_engine.sv
// Directed bench: game-RAM and NVRAM models around two engines (default and a
// 4-byte NVRAM variant for overflow), hand-computed expectations.
module tb_segasys1_hiscore_engine;
    import segasys1_hs_pkg::*;

    localparam int PAUSE_CYC = 16;
    localparam logic [15:0] RAM_BASE = {HS_MAIN_RAM_HI, 12'h000};

    logic clk48M = 1'b0;
    logic reset  = 1'b1;
    always #5 clk48M = ~clk48M;

    logic       cfg_we, start_save, start_rest, start_save2;
    logic [1:0] cfg_idx;
    logic [15:0] cfg_start;
    logic [8:0] cfg_len;

    logic pause_n, hswe, nv_we, busy, done, ovf;
    logic [15:0] hsad;
    logic [7:0]  hsdi, hsdo, nv_dout, nv_din;
    logic [9:0]  nv_ad;

    logic pause_n2, hswe2, nv_we2, busy2, done2, ovf2;
    logic [15:0] hsad2;
    logic [7:0]  hsdi2, hsdo2, nv_dout2, nv_din2;
    logic [1:0]  nv_ad2;

    segasys1_hiscore_engine u_dut (
        .clk48M(clk48M), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .start_save(start_save),
        .start_rest(start_rest), .PAUSE_N(pause_n), .HSAD(hsad), .HSDI(hsdi),
        .HSWE(hswe), .HSDO(hsdo), .nv_ad(nv_ad), .nv_dout(nv_dout),
        .nv_we(nv_we), .nv_din(nv_din), .busy(busy), .done(done), .ovf(ovf)
    );

    segasys1_hiscore_engine #(.NV_AW(2)) u_dut2 (
        .clk48M(clk48M), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .start_save(start_save2),
        .start_rest(1'b0), .PAUSE_N(pause_n2), .HSAD(hsad2), .HSDI(hsdi2),
        .HSWE(hswe2), .HSDO(hsdo2), .nv_ad(nv_ad2), .nv_dout(nv_dout2),
        .nv_we(nv_we2), .nv_din(nv_din2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    // Memory models: game RAM with 2-clk read latency, NVRAMs with 1-clk
    logic [7:0]  ram [0:65535];
    logic [7:0]  nv  [0:1023];
    logic [7:0]  nv2 [0:3];
    logic [15:0] rd_a, rd_a2;
    logic        pk_ram = 1'b0, pk_nv = 1'b0;
    logic [15:0] pk_a = '0;
    logic [7:0]  pk_d = '0;

    always @(posedge clk48M) begin
        if (pk_ram)     ram[pk_a] <= pk_d;
        else if (hswe)  ram[hsad] <= hsdi;
        else if (hswe2) ram[hsad2] <= hsdi2;
        rd_a  <= hsad;
        hsdo  <= ram[rd_a];
        rd_a2 <= hsad2;
        hsdo2 <= ram[rd_a2];
        if (pk_nv)      nv[pk_a[9:0]] <= pk_d;
        else if (nv_we) nv[nv_ad] <= nv_dout;
        nv_din <= nv[nv_ad];
        if (nv_we2) nv2[nv_ad2] <= nv_dout2;
        nv_din2 <= nv2[nv_ad2];
    end

    // Event monitors (sample pre-edge values)
    int nvwe_cnt = 0, hswe_cnt = 0, hswe_dbl = 0, done_cnt = 0;
    int nvwe2_cnt = 0, done2_cnt = 0, pause_lo = 0;
    bit hswe_q = 1'b0, acc = 1'b0;
    logic [15:0] hsad_q = '0;

    always @(posedge clk48M) begin
        if (nv_we)  nvwe_cnt++;
        if (done)   done_cnt++;
        if (nv_we2) nvwe2_cnt++;
        if (done2)  done2_cnt++;
        if (hswe) begin
            hswe_cnt++;
            if (hswe_q) hswe_dbl++;
        end
        hswe_q = hswe;
        if (!acc) begin
            if (hsad != hsad_q) acc = 1'b1;
            else if (!pause_n) pause_lo++;
        end
        hsad_q = hsad;
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int i, input logic [15:0] s, input logic [8:0] l);
        @(negedge clk48M);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_start = s; cfg_len = l;
        @(negedge clk48M);
        cfg_we = 1'b0;
    endtask

    task automatic poke_ram(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk48M); pk_ram = 1'b1; pk_a = a; pk_d = d;
        @(negedge clk48M); pk_ram = 1'b0;
    endtask

    task automatic poke_nv(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk48M); pk_nv = 1'b1; pk_a = {6'd0, a}; pk_d = d;
        @(negedge clk48M); pk_nv = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit second);
        bit seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk48M); #1;
            seen = second ? done2 : done;
        end
        if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    int b_nv, b_hs, b_dn, b_nv2, b_dn2;
    logic [7:0] exp3 [6] = '{8'hA1, 8'hA2, 8'h55, 8'h66, 8'h77, 8'h00};

    initial begin
        cfg_we = 0; cfg_idx = 0; cfg_start = 0; cfg_len = 0;
        start_save = 0; start_rest = 0; start_save2 = 0;
        repeat (3) @(negedge clk48M);

        chk("rst PAUSE_N", pause_n, 1); chk("rst HSWE", hswe, 0);
        chk("rst nv_we", nv_we, 0);     chk("rst busy", busy, 0);
        chk("rst done", done, 0);       chk("rst ovf", ovf, 0);
        chk("rst HSAD", hsad, 0);       chk("rst HSDI", hsdi, 0);
        chk("rst nv_ad", nv_ad, 0);
        reset = 1'b0;

        // Basic save of 4 bytes
        cfg(0, RAM_BASE, 9'd4);
        for (int i = 0; i < 4; i++) poke_ram(RAM_BASE + 16'(i), 8'(8'h11 * (i + 1)));
        b_nv = nvwe_cnt; b_dn = done_cnt;
        @(negedge clk48M); start_save = 1;
        @(negedge clk48M); start_save = 0;
        chk("busy after start", busy, 1);
        chk("pause low", pause_n, 0);
        wait_done("save1", 0);
        chk("fin busy", busy, 0);
        chk("fin PAUSE_N", pause_n, 1);
        repeat (3) @(negedge clk48M);
        for (int i = 0; i < 4; i++) chk($sformatf("save1 nv[%0d]", i), nv[i], 8'(8'h11 * (i + 1)));
        chk("save1 writes", nvwe_cnt - b_nv, 4);
        chk("save1 done count", done_cnt - b_dn, 1);
        chk("pause before access", 32'(pause_lo >= PAUSE_CYC), 1);

        // Restore 4 bytes
        for (int i = 0; i < 4; i++) poke_nv(10'(i), 8'(8'hA1 + i));
        b_hs = hswe_cnt;
        @(negedge clk48M); start_rest = 1;
        @(negedge clk48M); start_rest = 0;
        wait_done("rest1", 0);
        repeat (3) @(negedge clk48M);
        chk("rest1 HSWE pulses", hswe_cnt - b_hs, 4);
        chk("rest1 HSWE single", hswe_dbl, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rest1 ram[%0d]", i), ram[RAM_BASE + 16'(i)], 8'(8'hA1 + i));

        // Two ranges with a disabled entry between them
        cfg(0, RAM_BASE, 9'd2);
        cfg(2, 16'hD800, 9'd3);
        poke_ram(16'hD800, 8'h55); poke_ram(16'hD801, 8'h66); poke_ram(16'hD802, 8'h77);
        for (int i = 0; i < 6; i++) poke_nv(10'(i), 8'h00);
        b_nv = nvwe_cnt;
        @(negedge clk48M); start_save = 1;
        @(negedge clk48M); start_save = 0;
        wait_done("save2", 0);
        repeat (3) @(negedge clk48M);
        for (int i = 0; i < 6; i++) chk($sformatf("save2 nv[%0d]", i), nv[i], exp3[i]);
        chk("save2 writes", nvwe_cnt - b_nv, 5);
        chk("save2 ovf", ovf, 0);

        // Simultaneous strobes, then strobes and cfg while busy
        poke_ram(RAM_BASE, 8'h5A);
        b_nv = nvwe_cnt; b_hs = hswe_cnt; b_dn = done_cnt;
        @(negedge clk48M); start_save = 1; start_rest = 1;
        @(negedge clk48M); start_save = 0; start_rest = 0;
        repeat (8) @(negedge clk48M);
        start_rest = 1;
        @(negedge clk48M); start_rest = 0; start_save = 1;
        @(negedge clk48M); start_save = 0;
        cfg(3, 16'hE000, 9'd5);
        wait_done("both", 0);
        repeat (40) @(negedge clk48M);
        chk("both writes", nvwe_cnt - b_nv, 5);
        chk("both no HSWE", hswe_cnt - b_hs, 0);
        chk("both nv[0]", nv[0], 8'h5A);
        chk("both done count", done_cnt - b_dn, 1);
        chk("both idle", busy, 0);
        b_nv = nvwe_cnt;
        @(negedge clk48M); start_save = 1;
        @(negedge clk48M); start_save = 0;
        wait_done("frozen", 0);
        repeat (3) @(negedge clk48M);
        chk("frozen table writes", nvwe_cnt - b_nv, 5);

        // HSAD wrap inside a range
        cfg(0, 16'hFFFE, 9'd4);
        cfg(2, 16'hD800, 9'd0);
        poke_ram(16'hFFFE, 8'hB1); poke_ram(16'hFFFF, 8'hB2);
        poke_ram(16'h0000, 8'hB3); poke_ram(16'h0001, 8'hB4);
        b_nv = nvwe_cnt;
        @(negedge clk48M); start_save = 1;
        @(negedge clk48M); start_save = 0;
        wait_done("wrap", 0);
        repeat (3) @(negedge clk48M);
        for (int i = 0; i < 4; i++) chk($sformatf("wrap nv[%0d]", i), nv[i], 8'(8'hB1 + i));
        chk("wrap writes", nvwe_cnt - b_nv, 4);

        // NVRAM overflow on the 4-byte instance
        cfg(0, RAM_BASE, 9'd6);
        for (int i = 0; i < 6; i++) poke_ram(RAM_BASE + 16'(i), 8'(8'h61 + i));
        b_nv2 = nvwe2_cnt; b_dn2 = done2_cnt;
        @(negedge clk48M); start_save2 = 1;
        @(negedge clk48M); start_save2 = 0;
        wait_done("ovf", 1);
        repeat (3) @(negedge clk48M);
        chk("ovf writes", nvwe2_cnt - b_nv2, 4);
        chk("ovf flag", ovf2, 1);
        chk("ovf done count", done2_cnt - b_dn2, 1);
        chk("ovf PAUSE_N", pause_n2, 1);
        chk("ovf busy", busy2, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("ovf nv2[%0d]", i), nv2[i], 8'(8'h61 + i));
        chk("no ovf main", ovf, 0);

        // Reset in the middle of a restore
        begin
            bit hit = 1'b0;
            @(negedge clk48M); start_rest = 1;
            @(negedge clk48M); start_rest = 0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(posedge clk48M); #1;
                hit = hswe;
            end
            if (!hit) chk("midrst HSWE timeout", 32'd0, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("midrst PAUSE_N", pause_n, 1);
        chk("midrst HSWE", hswe, 0);
        chk("midrst nv_we", nv_we, 0);
        @(negedge clk48M); reset = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst ovf2 cleared", ovf2, 0);
        b_hs = hswe_cnt; b_nv = nvwe_cnt; b_dn = done_cnt;
        repeat (5) @(negedge clk48M);
        chk("midrst no strobes", hswe_cnt - b_hs, 0);
        @(negedge clk48M); start_save = 1;
        @(negedge clk48M); start_save = 0;
        wait_done("cleared", 0);
        repeat (3) @(negedge clk48M);
        chk("cleared table writes", nvwe_cnt - b_nv, 0);
        chk("cleared done count", done_cnt - b_dn, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
